// File: rtl/alu4_cmd_sequencer_if.sv
// Command-side and result-side valid/ready bundle for alu4_cmd_sequencer.
// cmd_chain exists only when ALU4_CHAIN_EN is defined.
interface alu4_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
`ifdef ALU4_CHAIN_EN
  logic       cmd_chain;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_result;
  logic       out_cout;
  logic       out_err;

`ifdef ALU4_CHAIN_EN
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, out_ready,
    input  cmd_ready, out_valid, out_result, out_cout, out_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, out_ready,
    output cmd_ready, out_valid, out_result, out_cout, out_err
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, out_ready,
    input  cmd_ready, out_valid, out_result, out_cout, out_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, out_ready,
    output cmd_ready, out_valid, out_result, out_cout, out_err
  );
`endif
endinterface

// File: rtl/alu4_cmd_sequencer.sv
// Command FIFO + result register around the 4-bit ALU; ALU4_CHAIN_EN adds cmd_chain (operand1 = last result).
// Captured one edge after push, 1 result/cycle; cmd_ready = !full, out_* held while out_ready is low.
module alu4_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu4_cmd_sequencer_if.slave  bus,
  output logic [2:0]           alu_sig,
  output logic [3:0]           alu_op1,
  output logic [3:0]           alu_op2,
  input  logic [4:0]           alu_result,
  input  logic                 alu_cout,
  output logic [CNT_W-1:0]     ops_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_REM = 3'd4;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
`ifdef ALU4_CHAIN_EN
    logic       chain;
`endif
  } cmd_t;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  cmd_t        mem [DEPTH];
  cmd_t        cmd_in;
  cmd_t        head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        cap_err;
  logic        cap_cout;
  state_t      state;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.cmd_valid && !full;
  assign pop   = !empty && ((state == S_EMPTY) || bus.out_ready);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign bus.cmd_ready = !full;
  assign bus.out_valid = (state == S_FULL);

  always_comb begin
    cmd_in    = '0;
    cmd_in.op = bus.cmd_op;
    cmd_in.a  = bus.cmd_a;
    cmd_in.b  = bus.cmd_b;
`ifdef ALU4_CHAIN_EN
    cmd_in.chain = bus.cmd_chain;
`endif
  end

  always_comb begin
    alu_sig = '0;
    alu_op1 = '0;
    alu_op2 = '0;
    if (!empty) begin
      alu_sig = head.op;
      alu_op1 = head.a;
      alu_op2 = head.b;
`ifdef ALU4_CHAIN_EN
      // out_result is the latest capture whether it is still held or being accepted now.
      if (head.chain) alu_op1 = bus.out_result[3:0];
`endif
    end
  end

  assign cap_err  = ((alu_sig == OP_DIV) || (alu_sig == OP_REM)) && (alu_op2 == 4'd0);
  assign cap_cout = ((alu_sig == OP_ADD) || (alu_sig == OP_SUB)) && alu_cout;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_EMPTY;
      bus.out_result <= '0;
      bus.out_cout   <= 1'b0;
      bus.out_err    <= 1'b0;
      ops_done       <= '0;
    end else begin
      if ((state == S_FULL) && bus.out_ready) ops_done <= ops_done + CNT_ONE;
      case (state)
        S_EMPTY: begin
          if (pop) begin
            state          <= S_FULL;
            bus.out_result <= cap_err ? 5'd0 : alu_result;
            bus.out_cout   <= cap_cout;
            bus.out_err    <= cap_err;
          end
        end
        S_FULL: begin
          if (pop) begin
            bus.out_result <= cap_err ? 5'd0 : alu_result;
            bus.out_cout   <= cap_cout;
            bus.out_err    <= cap_err;
          end else if (bus.out_ready) begin
            state <= S_EMPTY;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end
endmodule
